// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input for two's-complement subtraction.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             bit_w;
    logic             maj_w;
    logic [WIDTH-1:0] res_next_w;
    logic [WIDTH-1:0] b_load_w;
    logic             carry_load_w;

    // Single full-adder cell; the new bit enters the result register at the MSB.
    assign bit_w      = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign maj_w      = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign res_next_w = (res_q >> 1) | (WIDTH'(bit_w) << (WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; the +1 rides in on the initial carry.
    assign b_load_w     = sub ? ~b : b;
    assign carry_load_w = sub;
`else
    assign b_load_w     = b;
    assign carry_load_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load_w;
                    res_d   = '0;
                    carry_d = carry_load_w;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = res_next_w;
                carry_d = maj_w;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = res_next_w;
                    cout_d  = maj_w;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance and a 1-bit (half-adder) instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       sub;

    logic       start1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (1'b0),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation from the current (idle or done) cycle and waits for done.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [7:0] exp_s, input logic exp_c);
        int unsigned n;
        logic [7:0]  held;
        held  = sum;
        a     = av;
        b     = bv;
        sub   = sv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        sub   = 1'b0;
        n     = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && n < 40) begin
            check({tag, "_held"}, 32'(sum), 32'(held));
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 32'd9);
        check({tag, "_sum"}, 32'(sum), 32'(exp_s));
        check({tag, "_cout"}, 32'(cout), 32'(exp_c));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_cout", 32'(cout), 32'd0);
            tick();
        end

        // n counts the accept edge too, so WIDTH=8 completes at n=9 (accept + 8 bit edges).
        run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        tick();
        check("done_pulse", 32'(done), 32'd0);
        check("sum_hold", 32'(sum), 32'h96);

        run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("b2b8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        tick();

        // Start while busy: the second strobe must be ignored.
        a = 8'h01; b = 8'h02; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
            else begin a = 8'h00; b = 8'h00; start = 1'b0; end
            check("ign_nodone", 32'(done), 32'd0);
            tick();
        end
        start = 1'b0;
        check("ign_done", 32'(done), 32'd1);
        check("ign_sum", 32'(sum), 32'h03);
        check("ign_cout", 32'(cout), 32'd0);
        tick();

        // Reset mid-operation.
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("abort_nodone", 32'(done), 32'd0);
            tick();
        end

        // WIDTH=1 half-adder behaviour.
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ab;
            ab = 2'(k);
            a1 = ab[1]; b1 = ab[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("w1_busy", 32'(busy1), 32'd1);
            check("w1_early", 32'(done1), 32'd0);
            tick();
            check("w1_done", 32'(done1), 32'd1);
            check("w1_sum", 32'(sum1), 32'(ab[1] ^ ab[0]));
            check("w1_cout", 32'(cout1), 32'(ab[1] & ab[0]));
        end
        check("w1_k0_sum_zero", 32'(sum1), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        tick();
        run_op("sub1001", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
        run_op("sub0102", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        run_op("add1001", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
